// File: rtl/codificador_7seg_pkg.sv
// Shared constants for the 7-segment bus snooper: segment order, pattern/code table,
// stability counter width and the decoded-sample type.
package codificador_7seg_pkg;

   // Bit positions of segments a..g inside the 7-bit bus (a is the MSB).
   localparam int SEG_A = 6;
   localparam int SEG_B = 5;
   localparam int SEG_C = 4;
   localparam int SEG_D = 3;
   localparam int SEG_E = 2;
   localparam int SEG_F = 1;
   localparam int SEG_G = 0;

   localparam logic [6:0] PADRAO_0       = 7'b0000001;
   localparam logic [6:0] PADRAO_1       = 7'b1001111;
   localparam logic [6:0] PADRAO_2       = 7'b0010010;
   localparam logic [6:0] PADRAO_3       = 7'b0000110;
   localparam logic [6:0] PADRAO_4       = 7'b1001100;
   localparam logic [6:0] PADRAO_5       = 7'b0100100;
   localparam logic [6:0] PADRAO_6       = 7'b0100000;
   localparam logic [6:0] PADRAO_7       = 7'b0001111;
   localparam logic [6:0] PADRAO_8       = 7'b0000000;
   localparam logic [6:0] PADRAO_9       = 7'b0000100;
   localparam logic [6:0] PADRAO_TRACO   = 7'b1111110;
   localparam logic [6:0] PADRAO_F       = 7'b0111000;
   localparam logic [6:0] PADRAO_APAGADO = 7'b1111111;

   localparam logic [3:0] CODIGO_TRACO   = 4'hA;
   localparam logic [3:0] CODIGO_F       = 4'hB;
   localparam logic [3:0] CODIGO_APAGADO = 4'hF;

   localparam int ESTAVEL_MAX = 15;
   localparam int CNT_W       = $clog2(ESTAVEL_MAX + 1);

   typedef struct packed {
      logic       desconhecido;
      logic [3:0] codigo;
   } amostra_t;

endpackage

// File: rtl/padrao_para_codigo.sv
// Combinational lookup from an active-low abcdefg pattern to its 4-bit code;
// patterns outside the table decode as blank with the unknown flag raised.
module padrao_para_codigo
   import codificador_7seg_pkg::*;
(
   input  logic [6:0] i_padrao,
   output logic [3:0] o_codigo,
   output logic       o_desconhecido
);

   always_comb begin
      // NOTE: outputs get a default before the case so no path leaves them unassigned (no latch).
      o_codigo       = CODIGO_APAGADO;
      o_desconhecido = 1'b0;
      case (i_padrao)
         PADRAO_0:       o_codigo = 4'h0;
         PADRAO_1:       o_codigo = 4'h1;
         PADRAO_2:       o_codigo = 4'h2;
         PADRAO_3:       o_codigo = 4'h3;
         PADRAO_4:       o_codigo = 4'h4;
         PADRAO_5:       o_codigo = 4'h5;
         PADRAO_6:       o_codigo = 4'h6;
         PADRAO_7:       o_codigo = 4'h7;
         PADRAO_8:       o_codigo = 4'h8;
         PADRAO_9:       o_codigo = 4'h9;
         PADRAO_TRACO:   o_codigo = CODIGO_TRACO;
         PADRAO_F:       o_codigo = CODIGO_F;
         PADRAO_APAGADO: o_codigo = CODIGO_APAGADO;
         default:        o_desconhecido = 1'b1;
      endcase
   end

endmodule

// File: rtl/codificador_7seg.sv
// Snoops a multiplexed 7-segment bus, debounces each digit with a stability counter,
// holds the committed codes and reports changes on a valid/ready event port.
module codificador_7seg
   import codificador_7seg_pkg::*;
#(
   parameter  int N_DIGITOS = 4,
   parameter  int ESTAVEL   = 3,
   localparam int W_IDX     = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [6:0]             seg,
   input  logic [N_DIGITOS-1:0]   an,
   output logic [4*N_DIGITOS-1:0] digitos,
   output logic [N_DIGITOS-1:0]   erro,
   output logic                   evt_valid,
   output logic [W_IDX-1:0]       evt_digito,
   output logic [3:0]             evt_codigo,
   input  logic                   evt_ready
);

   logic [6:0]                          r_seg;
   logic [N_DIGITOS-1:0]                r_an;
   logic [N_DIGITOS-1:0][3:0]           r_cand_cod, w_cand_cod_nxt;
   logic [N_DIGITOS-1:0]                r_cand_unk, w_cand_unk_nxt;
   logic [N_DIGITOS-1:0][CNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic [N_DIGITOS-1:0][3:0]           r_digitos, w_digitos_nxt;
   logic [N_DIGITOS-1:0]                r_erro, w_erro_nxt;
   logic [N_DIGITOS-1:0]                r_pend, w_pend_nxt;
   logic                                r_evt_valid;
   logic [W_IDX-1:0]                    r_evt_digito;
   logic [3:0]                          r_evt_codigo;

   logic [3:0]                          w_codigo;
   logic                                w_desconhecido;
   logic [N_DIGITOS-1:0]                w_sel;
   logic                                w_qual;
   logic                                w_transf;
   logic [W_IDX-1:0]                    w_menor;
   logic [3:0]                          w_cod_menor;

   padrao_para_codigo u_padrao (
      .i_padrao       (r_seg),
      .o_codigo       (w_codigo),
      .o_desconhecido (w_desconhecido)
   );

   // A sample counts only when exactly one anode is driven low.
   assign w_sel    = ~r_an;
   assign w_qual   = (w_sel != '0) && ((w_sel & (w_sel - 1'b1)) == '0);
   assign w_transf = r_evt_valid & evt_ready;

   always_comb begin
      w_cand_cod_nxt = r_cand_cod;
      w_cand_unk_nxt = r_cand_unk;
      w_cnt_nxt      = r_cnt;
      w_digitos_nxt  = r_digitos;
      w_erro_nxt     = r_erro;
      w_pend_nxt     = r_pend;
      for (int i = 0; i < N_DIGITOS; i++) begin
         if (w_transf && (r_evt_digito == W_IDX'(i)))
            w_pend_nxt[i] = 1'b0;
         if (w_qual && w_sel[i]) begin
            if ({w_codigo, w_desconhecido} == {r_cand_cod[i], r_cand_unk[i]}) begin
               if (r_cnt[i] != CNT_W'(ESTAVEL))
                  w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end else begin
               w_cand_cod_nxt[i] = w_codigo;
               w_cand_unk_nxt[i] = w_desconhecido;
               w_cnt_nxt[i]      = CNT_W'(1);
            end
            // A saturated counter recommits the same value, which changes nothing.
            if (w_cnt_nxt[i] == CNT_W'(ESTAVEL)) begin
               w_digitos_nxt[i] = w_cand_cod_nxt[i];
               w_erro_nxt[i]    = w_cand_unk_nxt[i];
               if ({w_cand_cod_nxt[i], w_cand_unk_nxt[i]} != {r_digitos[i], r_erro[i]})
                  w_pend_nxt[i] = 1'b1;
            end
         end
      end
   end

   // Scan from the top so the lowest pending index is the last one written.
   always_comb begin
      w_menor     = '0;
      w_cod_menor = r_digitos[0];
      for (int i = N_DIGITOS - 1; i >= 0; i--) begin
         if (r_pend[i]) begin
            w_menor     = W_IDX'(i);
            w_cod_menor = r_digitos[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (!rst_n) begin
         r_seg        <= PADRAO_APAGADO;
         r_an         <= '1;
         r_cand_cod   <= {N_DIGITOS{CODIGO_APAGADO}};
         r_cand_unk   <= '0;
         r_cnt        <= '0;
         r_digitos    <= {N_DIGITOS{CODIGO_APAGADO}};
         r_erro       <= '0;
         r_pend       <= '0;
         r_evt_valid  <= 1'b0;
         r_evt_digito <= '0;
         r_evt_codigo <= CODIGO_APAGADO;
      end else begin
         r_seg      <= seg;
         r_an       <= an;
         r_cand_cod <= w_cand_cod_nxt;
         r_cand_unk <= w_cand_unk_nxt;
         r_cnt      <= w_cnt_nxt;
         r_digitos  <= w_digitos_nxt;
         r_erro     <= w_erro_nxt;
         r_pend     <= w_pend_nxt;
         if (w_transf) begin
            r_evt_valid <= 1'b0;
         end else if (!r_evt_valid && (r_pend != '0)) begin
            r_evt_valid  <= 1'b1;
            r_evt_digito <= w_menor;
            r_evt_codigo <= w_cod_menor;
         end
      end
   end

   assign digitos    = r_digitos;
   assign erro       = r_erro;
   assign evt_valid  = r_evt_valid;
   assign evt_digito = r_evt_digito;
   assign evt_codigo = r_evt_codigo;

endmodule

// File: tb/tb_codificador_7seg.sv
// Directed bench for codificador_7seg: reset, debounce latency, glitch rejection,
// scan with event backpressure, unknown patterns, illegal selects and mid-run reset.
module tb_codificador_7seg;

   localparam logic [6:0] P1  = 7'b1001111;
   localparam logic [6:0] P2  = 7'b0010010;
   localparam logic [6:0] P3  = 7'b0000110;
   localparam logic [6:0] P4  = 7'b1001100;
   localparam logic [6:0] P5  = 7'b0100100;
   localparam logic [6:0] P7  = 7'b0001111;
   localparam logic [6:0] P8  = 7'b0000000;
   localparam logic [6:0] P9  = 7'b0000100;
   localparam logic [6:0] PX  = 7'b1010101;
   localparam logic [6:0] PBL = 7'b1111111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [15:0] digitos;
   logic [3:0]  erro;
   logic        evt_valid;
   logic [1:0]  evt_digito;
   logic [3:0]  evt_codigo;
   logic        evt_ready;

   int n_assert = 0;
   int n_fail   = 0;
   bit saw9     = 1'b0;

   codificador_7seg #(.N_DIGITOS(4), .ESTAVEL(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seg        (seg),
      .an         (an),
      .digitos    (digitos),
      .erro       (erro),
      .evt_valid  (evt_valid),
      .evt_digito (evt_digito),
      .evt_codigo (evt_codigo),
      .evt_ready  (evt_ready)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (evt_valid && evt_codigo == 4'h9) saw9 <= 1'b1;

   task automatic drv(input logic [3:0] a, input logic [6:0] s);
      an  = a;
      seg = s;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drv(4'b1111, PBL);
   endtask

   task automatic wait_evt(input int limite, output bit ok);
      for (int k = 0; k < limite && !evt_valid; k++) idle(1);
      ok = evt_valid;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      evt_ready = 1'b0;
      drv(4'($urandom), 7'($urandom));
      drv(4'($urandom), 7'($urandom));
      n_assert++;
      if (digitos !== 16'hFFFF) begin
         n_fail++; $display("FAIL reset_digitos: got %h expected %h", digitos, 16'hFFFF);
      end
      n_assert++;
      if (erro !== 4'h0) begin
         n_fail++; $display("FAIL reset_erro: got %b expected %b", erro, 4'h0);
      end
      n_assert++;
      if (evt_valid !== 1'b0 || evt_digito !== 2'd0 || evt_codigo !== 4'hF) begin
         n_fail++; $display("FAIL reset_evt: got v=%b d=%0d c=%h expected v=0 d=0 c=f",
                            evt_valid, evt_digito, evt_codigo);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single_digit();
      repeat (3) drv(4'b1110, P2);
      n_assert++;
      if (digitos[3:0] !== 4'hF) begin
         n_fail++; $display("FAIL single_early: got %h expected %h", digitos[3:0], 4'hF);
      end
      idle(1);
      n_assert++;
      if (digitos[3:0] !== 4'h2) begin
         n_fail++; $display("FAIL single_commit: got %h expected %h", digitos[3:0], 4'h2);
      end
      n_assert++;
      if (evt_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_evt_early: got %b expected %b", evt_valid, 1'b0);
      end
      idle(1);
      n_assert++;
      if (evt_valid !== 1'b1 || evt_digito !== 2'd0 || evt_codigo !== 4'h2) begin
         n_fail++; $display("FAIL single_evt: got v=%b d=%0d c=%h expected v=1 d=0 c=2",
                            evt_valid, evt_digito, evt_codigo);
      end
      evt_ready = 1'b1;
      idle(1);
      evt_ready = 1'b0;
      n_assert++;
      if (evt_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_evt_drop: got %b expected %b", evt_valid, 1'b0);
      end
      idle(3);
      n_assert++;
      if (evt_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_no_repeat: got %b expected %b", evt_valid, 1'b0);
      end
   endtask

   task automatic test_glitch();
      bit ok;
      repeat (2) drv(4'b1101, P3);
      drv(4'b1101, P9);
      repeat (3) drv(4'b1101, P3);
      n_assert++;
      if (digitos[7:4] !== 4'hF) begin
         n_fail++; $display("FAIL glitch_early: got %h expected %h", digitos[7:4], 4'hF);
      end
      idle(1);
      n_assert++;
      if (digitos[7:4] !== 4'h3) begin
         n_fail++; $display("FAIL glitch_commit: got %h expected %h", digitos[7:4], 4'h3);
      end
      wait_evt(5, ok);
      n_assert++;
      if (!ok || evt_digito !== 2'd1 || evt_codigo !== 4'h3) begin
         n_fail++; $display("FAIL glitch_evt: got ok=%b d=%0d c=%h expected ok=1 d=1 c=3",
                            ok, evt_digito, evt_codigo);
      end
      evt_ready = 1'b1;
      idle(1);
      evt_ready = 1'b0;
      idle(2);
      n_assert++;
      if (saw9 !== 1'b0) begin
         n_fail++; $display("FAIL glitch_saw9: got %b expected %b", saw9, 1'b0);
      end
   endtask

   task automatic test_scan_backpressure();
      bit ok;
      for (int r = 0; r < 3; r++) begin
         drv(4'b1110, P1);
         drv(4'b1101, P2);
         drv(4'b1011, P3);
         drv(4'b0111, P4);
      end
      idle(1);
      n_assert++;
      if (digitos !== 16'h4321) begin
         n_fail++; $display("FAIL scan_digitos: got %h expected %h", digitos, 16'h4321);
      end
      for (int k = 0; k < 4; k++) begin
         wait_evt(6, ok);
         n_assert++;
         if (!ok) begin
            n_fail++; $display("FAIL scan_evt_timeout: got %b expected %b (event %0d)", ok, 1'b1, k);
         end
         for (int c = 0; c < 5; c++) begin
            n_assert++;
            if (evt_valid !== 1'b1 || evt_digito !== 2'(k) || evt_codigo !== 4'(k + 1)) begin
               n_fail++; $display("FAIL scan_hold: got v=%b d=%0d c=%h expected v=1 d=%0d c=%0d",
                                  evt_valid, evt_digito, evt_codigo, k, k + 1);
            end
            idle(1);
         end
         evt_ready = 1'b1;
         idle(1);
         evt_ready = 1'b0;
         n_assert++;
         if (evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL scan_drop: got %b expected %b", evt_valid, 1'b0);
         end
         if (k < 3) begin
            idle(1);
            n_assert++;
            if (evt_valid !== 1'b1) begin
               n_fail++; $display("FAIL scan_next: got %b expected %b", evt_valid, 1'b1);
            end
         end
      end
      idle(3);
      n_assert++;
      if (evt_valid !== 1'b0) begin
         n_fail++; $display("FAIL scan_extra_evt: got %b expected %b", evt_valid, 1'b0);
      end
   endtask

   task automatic test_unknown_illegal();
      bit ok;
      bit any_evt = 1'b0;
      repeat (3) drv(4'b1011, PX);
      idle(1);
      n_assert++;
      if (erro !== 4'b0100 || digitos !== 16'h4F21) begin
         n_fail++; $display("FAIL unk_commit: got erro=%b dig=%h expected erro=0100 dig=4f21",
                            erro, digitos);
      end
      wait_evt(5, ok);
      n_assert++;
      if (!ok || evt_digito !== 2'd2 || evt_codigo !== 4'hF) begin
         n_fail++; $display("FAIL unk_evt: got ok=%b d=%0d c=%h expected ok=1 d=2 c=f",
                            ok, evt_digito, evt_codigo);
      end
      evt_ready = 1'b1;
      idle(1);
      evt_ready = 1'b0;
      idle(3);
      n_assert++;
      if (evt_valid !== 1'b0) begin
         n_fail++; $display("FAIL unk_single_evt: got %b expected %b", evt_valid, 1'b0);
      end
      repeat (2) drv(4'b0111, P5);
      for (int c = 0; c < 10; c++) begin
         drv((c < 5) ? 4'b0000 : 4'b1111, P5);
         if (evt_valid) any_evt = 1'b1;
      end
      drv(4'b0111, P5);
      n_assert++;
      if (digitos !== 16'h4F21 || erro !== 4'b0100 || any_evt !== 1'b0) begin
         n_fail++; $display("FAIL illegal_hold: got dig=%h erro=%b evt=%b expected dig=4f21 erro=0100 evt=0",
                            digitos, erro, any_evt);
      end
      idle(1);
      n_assert++;
      if (digitos !== 16'h5F21) begin
         n_fail++; $display("FAIL illegal_resume: got %h expected %h", digitos, 16'h5F21);
      end
      wait_evt(5, ok);
      n_assert++;
      if (!ok || evt_digito !== 2'd3 || evt_codigo !== 4'h5) begin
         n_fail++; $display("FAIL illegal_evt: got ok=%b d=%0d c=%h expected ok=1 d=3 c=5",
                            ok, evt_digito, evt_codigo);
      end
      evt_ready = 1'b1;
      idle(1);
      evt_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit ok;
      repeat (3) drv(4'b1110, P8);
      idle(2);
      n_assert++;
      if (evt_valid !== 1'b1 || evt_digito !== 2'd0 || evt_codigo !== 4'h8) begin
         n_fail++; $display("FAIL mid_pre_evt: got v=%b d=%0d c=%h expected v=1 d=0 c=8",
                            evt_valid, evt_digito, evt_codigo);
      end
      repeat (2) drv(4'b0111, P7);
      idle(1);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      n_assert++;
      if (digitos !== 16'hFFFF || erro !== 4'h0 || evt_valid !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset: got dig=%h erro=%b v=%b expected dig=ffff erro=0000 v=0",
                            digitos, erro, evt_valid);
      end
      repeat (2) drv(4'b0111, P7);
      idle(1);
      n_assert++;
      if (digitos !== 16'hFFFF) begin
         n_fail++; $display("FAIL mid_no_commit: got %h expected %h", digitos, 16'hFFFF);
      end
      drv(4'b0111, P7);
      idle(1);
      n_assert++;
      if (digitos !== 16'h7FFF) begin
         n_fail++; $display("FAIL mid_commit: got %h expected %h", digitos, 16'h7FFF);
      end
      wait_evt(5, ok);
      n_assert++;
      if (!ok || evt_digito !== 2'd3 || evt_codigo !== 4'h7) begin
         n_fail++; $display("FAIL mid_evt: got ok=%b d=%0d c=%h expected ok=1 d=3 c=7",
                            ok, evt_digito, evt_codigo);
      end
      evt_ready = 1'b1;
      idle(1);
      evt_ready = 1'b0;
      idle(3);
      n_assert++;
      if (evt_valid !== 1'b0) begin
         n_fail++; $display("FAIL mid_stale_evt: got %b expected %b", evt_valid, 1'b0);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      evt_ready = 1'b0;
      an        = 4'b1111;
      seg       = PBL;
      #2;
      test_reset();
      test_single_digit();
      test_glitch();
      test_scan_backpressure();
      test_unknown_illegal();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
